interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Interrupt sequencer directly downstream of the general-group decoder. Consumes the decoded EIX/DIX/RETIX strobes and the FETCH/DECODE/EXECUTE/COMMIT phase signals. Maintains the global interrupt-enable flag and a pending-interrupt register. At an instruction boundary it raises an interrupt request with a vector address, which the phase decoder and PC logic use to redirect the next fetch. Nesting is not supported; one interrupt is in service at a time.

## Interface
- N_INT, 4, number of interrupt lines; index 0 is highest priority.
- VECTOR_BASE, 16'h0008, vector address of line 0.
- VECTOR_STRIDE, 16'h0004, address spacing between consecutive vectors.

- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- FETCH, DECODE, EXECUTE, COMMIT  in  1 each  one-hot instruction phase from the phase decoder.
- EIX  in  1  enable-interrupts strobe from the general-group decoder; held through COMMIT.
- DIX  in  1  disable-interrupts strobe; held through COMMIT.
- RETIX  in  1  return-from-interrupt strobe; held through COMMIT.
- INT  in  N_INT  asynchronous-origin interrupt lines, already synchronised upstream; rising-edge triggered.
- IE  out  1  global interrupt enable.
- INT_REQ  out  1  request to replace the next fetch with an interrupt entry.
- VECTOR  out  16  entry address; valid whenever INT_REQ=1.
- INT_ACK  out  1  one-cycle pulse when entry is taken.
- IN_SERVICE  out  N_INT  one-hot indication of the line currently being serviced.
- PENDING  out  N_INT  latched, not-yet-serviced edges.

## Operation
- Edge detect: a rising edge on INT[i] is seen as INT[i]=1 with the previous sample 0. It sets PENDING[i]. The previous-sample register resets to 0.
- IE update, on the COMMIT cycle only:
  - DIX clears IE.
  - EIX sets IE.
  - RETIX sets IE.
  - If DIX and EIX are both asserted, DIX wins.
- State machine with three states: IDLE, REQ, SERVICE. All are entered via RESET→IDLE.
- IDLE→REQ on a COMMIT cycle with IE=1 and PENDING≠0 after that cycle's IE update.
  - The winning index IDX is the lowest set PENDING bit, captured on that edge.
- REQ behaviour:
  - INT_REQ=1.
  - VECTOR = VECTOR_BASE + IDX×VECTOR_STRIDE, using 16-bit modulo arithmetic.
- REQ→SERVICE on the first cycle where FETCH=1. On that edge:
  - clear PENDING[IDX];
  - clear IE;
  - set IN_SERVICE[IDX];
  - pulse INT_ACK high for exactly that FETCH cycle (combinational on REQ & FETCH).
- SERVICE→IDLE on a COMMIT cycle with RETIX=1: clear IN_SERVICE and set IE.
  - New edges arriving during SERVICE accumulate in PENDING.
- RETIX in IDLE or REQ only sets IE; the state is unchanged.
- In REQ, DIX at COMMIT clears IE but does not cancel the request. IDX is frozen once REQ is entered.
- If a new edge arrives on line IDX in the same cycle its PENDING bit is cleared, the set wins and the bit stays 1.
- When no request is active (state ≠ REQ), VECTOR holds VECTOR_BASE.

## Timing
- Reset values:
  - IE=0, INT_REQ=0, INT_ACK=0;
  - VECTOR=VECTOR_BASE;
  - IN_SERVICE=0, PENDING=0;
  - state IDLE, IDX=0.
- Edge to PENDING: 1 cycle. PENDING is registered on the edge after INT rises.
- COMMIT to INT_REQ: INT_REQ is high from the cycle after the qualifying COMMIT, so it coincides with the next FETCH.
  - Minimum INT_REQ width: 1 cycle.
  - INT_REQ drops the cycle after INT_ACK.
- EI then interrupt: an edge already pending when EI commits is requested at that same COMMIT, with no extra instruction delay.
- RESET asserted mid-REQ or mid-SERVICE returns to IDLE on that edge, with all outputs at reset values. Edges during RESET are ignored.

## Structure
- Shared constants file (constants.v) gains:
  - state encodings `INTC_IDLE=2'b00, `INTC_REQ=2'b01, `INTC_SERVICE=2'b10;
  - default vector base and stride constants.
- Sub-module interrupt_edge_detect: N_INT-wide previous-sample register plus rising-edge pulse output.
- The priority encoder and state machine live in the top module.

## Test plan
- Reset: hold RESET 2 cycles while INT=4'b1111 → all outputs at reset values, PENDING=0 after release, since the lines never rose after reset.
- Disabled pending: pulse INT[2] with IE=0 → PENDING=4'b0100, INT_REQ stays 0 through two full instruction cycles.
- Enable and enter:
  - commit EI with PENDING=4'b0100 → next cycle INT_REQ=1, VECTOR=16'h0010;
  - at FETCH INT_ACK=1 for one cycle;
  - then IE=0, IN_SERVICE=4'b0100, PENDING=0.
- Priority and queueing:
  - INT[3] and INT[1] rise in the same cycle with IE=1 → line 1 is serviced first, VECTOR=16'h000C, PENDING=4'b1000 during SERVICE;
  - RETI commit → IE=1, IDLE;
  - the same COMMIT requests line 3 with VECTOR=16'h0014.
- Boundary cases:
  - DIX and EIX both high at COMMIT → IE=0;
  - RETIX in IDLE → IE=1 with no state change;
  - an edge on IDX coincident with INT_ACK → PENDING[IDX] remains 1.
- Reset mid-SERVICE: assert RESET for 1 cycle → IN_SERVICE=0, IE=0, IDLE, VECTOR=16'h0008.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants and types for the interrupt sequencer.
package interrupt_controller_pkg;

   localparam int unsigned INTC_N_INT         = 4;
   localparam logic [15:0] INTC_VECTOR_BASE   = 16'h0008;
   localparam logic [15:0] INTC_VECTOR_STRIDE = 16'h0004;

   typedef enum logic [1:0] {
      INTC_IDLE    = 2'b00,
      INTC_REQ     = 2'b01,
      INTC_SERVICE = 2'b10
   } intc_state_t;

endpackage

// File: rtl/interrupt_controller_edge_detect.sv
// Rising-edge detector for the (already synchronised) interrupt lines.
module interrupt_edge_detect #(
   parameter int unsigned N_INT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_INT-1:0] lines,
   output logic [N_INT-1:0] rise_c
);

   logic [N_INT-1:0] prev;

   // Previous-sample register; cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= '0;
      end else begin
         prev <= lines;
      end
   end

   assign rise_c = lines & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt sequencer: IE flag, pending latch, priority pick and entry handshake.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned N_INT         = INTC_N_INT,
   parameter logic [15:0] VECTOR_BASE   = INTC_VECTOR_BASE,
   parameter logic [15:0] VECTOR_STRIDE = INTC_VECTOR_STRIDE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch,
   input  logic             decode,
   input  logic             execute,
   input  logic             commit,
   input  logic             eix,
   input  logic             dix,
   input  logic             retix,
   input  logic [N_INT-1:0] int_lines,
   output logic             ie,
   output logic             int_req,
   output logic [15:0]      vector,
   output logic             int_ack,
   output logic [N_INT-1:0] in_service,
   output logic [N_INT-1:0] pending
);

   localparam int unsigned IDX_W = (N_INT > 1) ? $clog2(N_INT) : 1;

   intc_state_t      state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] win_idx;
   logic [N_INT-1:0] rise;
   logic [N_INT-1:0] idx_mask;
   logic             ie_upd;
   logic             any_pending;
   logic             phase_unused;

   // Only the fetch and commit phases matter to this block.
   assign phase_unused = decode ^ execute;

   interrupt_edge_detect #(.N_INT(N_INT)) u_edge (
      .clk    (clk),
      .reset  (reset),
      .lines  (int_lines),
      .rise_c (rise)
   );

   // IE as it will be after this cycle's commit strobes (DIX dominates).
   always_comb begin
      ie_upd = ie;
      if (commit) begin
         if (dix) begin
            ie_upd = 1'b0;
         end else if (eix || retix) begin
            ie_upd = 1'b1;
         end
      end
   end

   // Priority encoder: lowest set pending bit wins.
   always_comb begin
      win_idx = '0;
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (pending[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   assign any_pending = |pending;
   assign idx_mask    = N_INT'(1) << idx;
   assign int_ack     = (state == INTC_REQ) && fetch;

   function automatic logic [15:0] vector_of(input logic [IDX_W-1:0] i);
      return 16'(VECTOR_BASE + 16'(16'(i) * VECTOR_STRIDE));
   endfunction

   // Sequencer state, pending/in-service bookkeeping and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INTC_IDLE;
         idx        <= '0;
         ie         <= 1'b0;
         int_req    <= 1'b0;
         vector     <= VECTOR_BASE;
         in_service <= '0;
         pending    <= '0;
      end else begin
         ie      <= ie_upd;
         pending <= pending | rise;
         case (state)
            INTC_IDLE: begin
               if (commit && ie_upd && any_pending) begin
                  state   <= INTC_REQ;
                  idx     <= win_idx;
                  int_req <= 1'b1;
                  vector  <= vector_of(win_idx);
               end
            end
            INTC_REQ: begin
               if (fetch) begin
                  state      <= INTC_SERVICE;
                  pending    <= (pending & ~idx_mask) | rise;
                  ie         <= 1'b0;
                  in_service <= idx_mask;
                  int_req    <= 1'b0;
                  vector     <= VECTOR_BASE;
               end
            end
            INTC_SERVICE: begin
               if (commit && retix) begin
                  in_service <= '0;
                  // A queued edge is requested at the same return commit.
                  if (ie_upd && any_pending) begin
                     state   <= INTC_REQ;
                     idx     <= win_idx;
                     int_req <= 1'b1;
                     vector  <= vector_of(win_idx);
                  end else begin
                     state <= INTC_IDLE;
                  end
               end
            end
            default: begin
               state <= INTC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

   localparam logic [3:0] PN = 4'b0000;
   localparam logic [3:0] PF = 4'b1000;
   localparam logic [3:0] PD = 4'b0100;
   localparam logic [3:0] PE = 4'b0010;
   localparam logic [3:0] PC = 4'b0001;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch, decode, execute, commit;
   logic        eix, dix, retix;
   logic [3:0]  irq;
   logic        ie, int_req, int_ack;
   logic [15:0] vector;
   logic [3:0]  in_service, pending;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   interrupt_controller dut (
      .clk        (clk),
      .reset      (reset),
      .fetch      (fetch),
      .decode     (decode),
      .execute    (execute),
      .commit     (commit),
      .eix        (eix),
      .dix        (dix),
      .retix      (retix),
      .int_lines  (irq),
      .ie         (ie),
      .int_req    (int_req),
      .vector     (vector),
      .int_ack    (int_ack),
      .in_service (in_service),
      .pending    (pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ph, input logic e, input logic d, input logic r);
      {fetch, decode, execute, commit} = ph;
      eix   = e;
      dix   = d;
      retix = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [3:0] ph, input logic e, input logic d, input logic r);
      drive(ph, e, d, r);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      irq   = 4'b1111;
      drive(PN, 1'b0, 1'b0, 1'b0);

      // Reset held two cycles with all lines high.
      tick();
      tick();
      chk("rst_ie", 32'(ie), 32'h0);
      chk("rst_int_req", 32'(int_req), 32'h0);
      chk("rst_int_ack", 32'(int_ack), 32'h0);
      chk("rst_vector", 32'(vector), 32'h0008);
      chk("rst_in_service", 32'(in_service), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      reset = 1'b0;
      irq   = 4'b0000;
      tick();
      tick();
      chk("post_rst_pending", 32'(pending), 32'h0);

      // Edge on line 2 with interrupts disabled.
      irq = 4'b0100;
      tick();
      chk("dis_pending", 32'(pending), 32'h4);
      irq = 4'b0000;
      for (int k = 0; k < 2; k++) begin
         step(PF, 1'b0, 1'b0, 1'b0);
         step(PD, 1'b0, 1'b0, 1'b0);
         step(PE, 1'b0, 1'b0, 1'b0);
         step(PC, 1'b0, 1'b0, 1'b0);
         chk("dis_no_req", 32'(int_req), 32'h0);
      end
      chk("dis_pending_hold", 32'(pending), 32'h4);

      // EI commit with line 2 pending requests on the same commit.
      step(PF, 1'b0, 1'b0, 1'b0);
      step(PD, 1'b0, 1'b0, 1'b0);
      step(PE, 1'b0, 1'b0, 1'b0);
      step(PC, 1'b1, 1'b0, 1'b0);
      chk("ei_ie", 32'(ie), 32'h1);
      chk("ei_int_req", 32'(int_req), 32'h1);
      chk("ei_vector", 32'(vector), 32'h0010);
      drive(PF, 1'b0, 1'b0, 1'b0);
      chk("ei_ack", 32'(int_ack), 32'h1);
      tick();
      chk("svc_int_req", 32'(int_req), 32'h0);
      chk("svc_ie", 32'(ie), 32'h0);
      chk("svc_in_service", 32'(in_service), 32'h4);
      chk("svc_pending", 32'(pending), 32'h0);
      chk("svc_vector", 32'(vector), 32'h0008);
      drive(PD, 1'b0, 1'b0, 1'b0);
      chk("svc_ack_drop", 32'(int_ack), 32'h0);
      tick();

      // Return with nothing pending: back to idle, IE set.
      step(PE, 1'b0, 1'b0, 1'b0);
      step(PC, 1'b0, 1'b0, 1'b1);
      chk("reti_ie", 32'(ie), 32'h1);
      chk("reti_in_service", 32'(in_service), 32'h0);
      chk("reti_int_req", 32'(int_req), 32'h0);

      // Lines 3 and 1 rise together; line 1 first.
      irq = 4'b1010;
      step(PF, 1'b0, 1'b0, 1'b0);
      chk("pri_pending", 32'(pending), 32'ha);
      chk("pri_no_req_yet", 32'(int_req), 32'h0);
      irq = 4'b0000;
      step(PD, 1'b0, 1'b0, 1'b0);
      step(PE, 1'b0, 1'b0, 1'b0);
      step(PC, 1'b0, 1'b0, 1'b0);
      chk("pri_int_req", 32'(int_req), 32'h1);
      chk("pri_vector1", 32'(vector), 32'h000c);
      drive(PF, 1'b0, 1'b0, 1'b0);
      chk("pri_ack1", 32'(int_ack), 32'h1);
      tick();
      chk("pri_in_service1", 32'(in_service), 32'h2);
      chk("pri_pending_svc", 32'(pending), 32'h8);
      chk("pri_ie_svc", 32'(ie), 32'h0);
      step(PD, 1'b0, 1'b0, 1'b0);
      step(PE, 1'b0, 1'b0, 1'b0);
      step(PC, 1'b0, 1'b0, 1'b1);
      chk("pri_reti_ie", 32'(ie), 32'h1);
      chk("pri_reti_in_service", 32'(in_service), 32'h0);
      chk("pri_int_req3", 32'(int_req), 32'h1);
      chk("pri_vector3", 32'(vector), 32'h0014);
      chk("pri_pending3", 32'(pending), 32'h8);

      // New edge on line 3 coincident with its acknowledge: set wins.
      irq = 4'b1000;
      drive(PF, 1'b0, 1'b0, 1'b0);
      chk("coin_ack", 32'(int_ack), 32'h1);
      tick();
      irq = 4'b0000;
      chk("coin_pending", 32'(pending), 32'h8);
      chk("coin_in_service", 32'(in_service), 32'h8);
      step(PD, 1'b0, 1'b0, 1'b0);
      step(PE, 1'b0, 1'b0, 1'b0);
      step(PC, 1'b0, 1'b0, 1'b1);
      chk("coin_rereq", 32'(int_req), 32'h1);
      chk("coin_vector", 32'(vector), 32'h0014);
      step(PF, 1'b0, 1'b0, 1'b0);
      chk("coin_svc", 32'(in_service), 32'h8);
      chk("coin_pending_clr", 32'(pending), 32'h0);

      // Reset in the middle of service.
      reset = 1'b1;
      irq   = 4'b0001;
      step(PD, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      irq   = 4'b0000;
      chk("mrst_in_service", 32'(in_service), 32'h0);
      chk("mrst_ie", 32'(ie), 32'h0);
      chk("mrst_int_req", 32'(int_req), 32'h0);
      chk("mrst_vector", 32'(vector), 32'h0008);
      chk("mrst_pending", 32'(pending), 32'h0);

      // IE update boundary cases with nothing pending.
      step(PC, 1'b1, 1'b0, 1'b0);
      chk("ei_only_ie", 32'(ie), 32'h1);
      step(PC, 1'b1, 1'b1, 1'b0);
      chk("dix_eix_ie", 32'(ie), 32'h0);
      step(PC, 1'b0, 1'b0, 1'b1);
      chk("reti_idle_ie", 32'(ie), 32'h1);
      chk("reti_idle_int_req", 32'(int_req), 32'h0);
      chk("reti_idle_in_service", 32'(in_service), 32'h0);
      step(PE, 1'b1, 1'b0, 1'b0);
      chk("ei_noncommit_ie", 32'(ie), 32'h1);
      step(PC, 1'b0, 1'b1, 1'b0);
      chk("di_ie", 32'(ie), 32'h0);

      // DIX while requesting clears IE but keeps the request.
      irq = 4'b0001;
      step(PF, 1'b0, 1'b0, 1'b0);
      irq = 4'b0000;
      chk("l0_pending", 32'(pending), 32'h1);
      step(PC, 1'b1, 1'b0, 1'b0);
      chk("l0_int_req", 32'(int_req), 32'h1);
      chk("l0_vector", 32'(vector), 32'h0008);
      step(PC, 1'b0, 1'b1, 1'b0);
      chk("req_dix_ie", 32'(ie), 32'h0);
      chk("req_dix_int_req", 32'(int_req), 32'h1);
      drive(PF, 1'b0, 1'b0, 1'b0);
      chk("l0_ack", 32'(int_ack), 32'h1);
      tick();
      chk("l0_in_service", 32'(in_service), 32'h1);
      chk("l0_int_req_drop", 32'(int_req), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
